// File: rtl/io_input_xmtr.sv
// io_input_xmtr
// Device-side transmitter for the processor input port. Bytes pushed by a
// host are queued in a small FIFO. They are then offered one at a time on
// input_bus, with in_dev_hs raised. Each byte is retired only after the
// processor answers with in_dev_ack.
//
// Ports:
//   g_clk       in   system clock, rising edge
//   g_clr       in   asynchronous active-low reset
//   wr_en       in   push wr_data this cycle (ignored while full)
//   wr_data     in   [7:0] byte to enqueue
//   in_dev_ack  in   processor acknowledge; the presented byte has been latched
//   in_dev_hs   out  high while input_bus holds a valid byte
//   input_bus   out  [7:0] byte presented to the processor
//   full        out  FIFO holds DEPTH entries
//   empty       out  FIFO holds no entries
//   count       out  [ADDR_W:0] FIFO occupancy
//   sent_count  out  [7:0] acknowledged bytes since reset, wraps at 256
//
// State table:
//   state      | meaning
//   ST_IDLE    | nothing presented, waiting for the FIFO to become non-empty
//   ST_PRESENT | in_dev_hs high, input_bus frozen, waiting for in_dev_ack
//   ST_RELEASE | byte retired, waiting for in_dev_ack to drop
//   ST_GAP     | enforced low time on in_dev_hs before the next byte
module io_input_xmtr #(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3,
    parameter int GAP_CYCLES = 1
) (
    input  logic              g_clk,
    input  logic              g_clr,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              in_dev_ack,
    output logic              in_dev_hs,
    output logic [7:0]        input_bus,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic [7:0]        sent_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_GAP     = 2'd3;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      GAP_LOAD = 4'(GAP_CYCLES);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [1:0]        r_state;
    logic [3:0]        r_gap;
    logic              r_hs;
    logic [7:0]        r_bus;
    logic [7:0]        r_sent;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    // A push while full is dropped even if a pop happens in the same cycle.
    assign w_push  = wr_en & ~w_full;
    assign w_pop   = (r_state == ST_PRESENT) & in_dev_ack;

    // Storage has no reset: contents are meaningless once the pointers clear.
    always_ff @(posedge g_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_state <= ST_IDLE;
            r_gap   <= '0;
            r_hs    <= 1'b0;
            r_bus   <= 8'h00;
            r_sent  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_bus   <= r_mem[r_rd_ptr];
                        r_hs    <= 1'b1;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (in_dev_ack) begin
                        r_sent  <= r_sent + 1'b1;
                        r_hs    <= 1'b0;
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!in_dev_ack) begin
                        r_gap   <= GAP_LOAD;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // Terminal count: the edge that takes the timer to zero
                    // also leaves the state, so GAP lasts GAP_CYCLES cycles.
                    if (r_gap <= 4'd1) begin
                        r_gap <= '0;
                        if (!w_empty) begin
                            r_bus   <= r_mem[r_rd_ptr];
                            r_hs    <= 1'b1;
                            r_state <= ST_PRESENT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: begin
                    r_hs    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_dev_hs  = r_hs;
    assign input_bus  = r_bus;
    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = r_count;
    assign sent_count = r_sent;

endmodule

// File: tb/tb_io_input_xmtr.sv
module tb_io_input_xmtr;

    logic       g_clk;
    logic       g_clr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       in_dev_ack;
    logic       in_dev_hs;
    logic [7:0] input_bus;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic [7:0] sent_count;

    int n_chk = 0;
    int n_err = 0;

    io_input_xmtr #(.DEPTH(8), .ADDR_W(3), .GAP_CYCLES(1)) dut (
        .g_clk      (g_clk),
        .g_clr      (g_clr),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .in_dev_ack (in_dev_ack),
        .in_dev_hs  (in_dev_hs),
        .input_bus  (input_bus),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .sent_count (sent_count)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge g_clk);
        g_clr = 1'b0;
        wr_en = 1'b0;
        in_dev_ack = 1'b0;
        @(negedge g_clk);
        g_clr = 1'b1;
        tick();
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    // Entered with the byte already presented; leaves after the gap edge.
    task automatic deliver(input string tag, input logic [7:0] exp);
        chk({tag, "_hs_hi"}, 32'(in_dev_hs), 32'd1);
        chk({tag, "_bus"}, 32'(input_bus), 32'(exp));
        in_dev_ack = 1'b1;
        tick();
        chk({tag, "_hs_lo1"}, 32'(in_dev_hs), 32'd0);
        in_dev_ack = 1'b0;
        tick();
        chk({tag, "_hs_lo2"}, 32'(in_dev_hs), 32'd0);
        tick();
    endtask

    initial begin
        logic [7:0] exp3 [3];
        exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
        g_clr = 1'b0;
        wr_en = 1'b0;
        wr_data = 8'h00;
        in_dev_ack = 1'b0;

        // Reset values
        #1;
        chk("rst_hs", 32'(in_dev_hs), 32'd0);
        chk("rst_bus", 32'(input_bus), 32'h00);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_sent", 32'(sent_count), 32'd0);
        @(negedge g_clk);
        g_clr = 1'b1;
        tick();

        // Single byte, ack held low
        push(8'h0A);
        chk("t1_hs_n", 32'(in_dev_hs), 32'd0);
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_empty", 32'(empty), 32'd0);
        tick();
        chk("t1_hs_n1", 32'(in_dev_hs), 32'd1);
        chk("t1_bus_n1", 32'(input_bus), 32'h0A);
        tick(); tick(); tick();
        chk("t1_hs_hold", 32'(in_dev_hs), 32'd1);
        chk("t1_bus_hold", 32'(input_bus), 32'h0A);
        chk("t1_count_hold", 32'(count), 32'd1);

        // Three bytes in order, one-cycle ack pulses
        do_reset();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk("t2_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) deliver("t2", exp3[i]);
        chk("t2_hs_end", 32'(in_dev_hs), 32'd0);
        chk("t2_sent", 32'(sent_count), 32'd3);
        chk("t2_empty", 32'(empty), 32'd1);
        chk("t2_bus_last", 32'(input_bus), 32'h33);

        // Fill to full, overflow drops
        do_reset();
        for (int i = 1; i <= 8; i++) push(8'(i));
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_count8", 32'(count), 32'd8);
        push(8'h09);
        chk("t3_drop_count", 32'(count), 32'd8);
        chk("t3_drop_full", 32'(full), 32'd1);
        // Push while full with a simultaneous pop is still dropped
        chk("t3_bus1", 32'(input_bus), 32'h01);
        wr_en = 1'b1;
        wr_data = 8'h99;
        in_dev_ack = 1'b1;
        tick();
        wr_en = 1'b0;
        in_dev_ack = 1'b0;
        chk("t3_pushpop_count", 32'(count), 32'd7);
        chk("t3_pushpop_full", 32'(full), 32'd0);
        chk("t3_pushpop_hs", 32'(in_dev_hs), 32'd0);
        tick();
        tick();
        for (int i = 2; i <= 8; i++) deliver("t3", 8'(i));
        tick(); tick();
        chk("t3_no_extra", 32'(in_dev_hs), 32'd0);
        chk("t3_sent", 32'(sent_count), 32'd8);
        chk("t3_empty", 32'(empty), 32'd1);

        // Ack held high: a single pop, stays released
        do_reset();
        push(8'hAA);
        push(8'h55);
        chk("t4_bus", 32'(input_bus), 32'hAA);
        in_dev_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hs_lo", 32'(in_dev_hs), 32'd0);
            chk("t4_count", 32'(count), 32'd1);
            chk("t4_sent", 32'(sent_count), 32'd1);
        end
        in_dev_ack = 1'b0;
        tick();
        chk("t4_gap_hs", 32'(in_dev_hs), 32'd0);
        tick();
        chk("t4_next_hs", 32'(in_dev_hs), 32'd1);
        chk("t4_next_bus", 32'(input_bus), 32'h55);

        // Asynchronous reset mid-transfer
        do_reset();
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        chk("t5_pre_hs", 32'(in_dev_hs), 32'd1);
        chk("t5_pre_count", 32'(count), 32'd3);
        #2;
        g_clr = 1'b0;
        #1;
        chk("t5_async_hs", 32'(in_dev_hs), 32'd0);
        chk("t5_async_count", 32'(count), 32'd0);
        chk("t5_async_empty", 32'(empty), 32'd1);
        @(negedge g_clk);
        g_clr = 1'b1;
        tick(); tick(); tick();
        chk("t5_idle_hs", 32'(in_dev_hs), 32'd0);
        chk("t5_idle_count", 32'(count), 32'd0);
        push(8'hD4);
        tick();
        chk("t5_new_hs", 32'(in_dev_hs), 32'd1);
        chk("t5_new_bus", 32'(input_bus), 32'hD4);

        // 256 bytes: sent_count wraps
        do_reset();
        for (int i = 0; i < 256; i++) begin
            push(8'(i));
            tick();
            deliver("t6", 8'(i));
            if (i == 254) chk("t6_sent_255", 32'(sent_count), 32'd255);
        end
        chk("t6_wrap", 32'(sent_count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/io_input_xmtr.md
Name: io_input_xmtr

Overview:
- Peripheral-side transmitter for the processor's input port.
- A host or bench loads bytes into an internal FIFO. The block presents them one at a time on `input_bus` and raises `in_dev_hs`. It then waits for the processor's `in_dev_ack` before retiring each byte.
- It is the device end of the `in_dev_hs` / `in_dev_ack` / `input_bus` handshake and sits outside the processor at system level.

Parameters:
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `ADDR_W`, 3: log2(`DEPTH`).
- `GAP_CYCLES`, 1: idle cycles with `in_dev_hs` low between bytes; 1 to 15.

Ports:
- `g_clk`  input  1  system clock; all state updates on the rising edge.
- `g_clr`  input  1  asynchronous, active-low reset.
- `wr_en`  input  1  push `wr_data` into the FIFO this cycle.
- `wr_data`  input  8  byte to enqueue.
- `in_dev_ack`  input  1  processor acknowledge; active high; byte has been latched.
- `in_dev_hs`  output  1  device handshake; high means `input_bus` holds a valid byte.
- `input_bus`  output  8  byte presented to the processor.
- `full`  output  1  FIFO holds `DEPTH` entries.
- `empty`  output  1  FIFO holds 0 entries.
- `count`  output  `ADDR_W`+1  current FIFO occupancy.
- `sent_count`  output  8  bytes acknowledged since reset; wraps 255 to 0.

Behaviour:
- Reset (`g_clr`=0, asynchronous):
  - Outputs: `in_dev_hs`=0, `input_bus`=8'h00, `count`=0, `empty`=1, `full`=0, `sent_count`=0.
  - State: FSM enters IDLE; read and write pointers cleared; FIFO contents discarded.
  - Reset asserted mid-transfer drops `in_dev_hs` immediately; the in-flight byte is lost.
- FIFO:
  - Push occurs when `wr_en`=1 and `full`=0. A push while full is dropped, even if a pop happens in the same cycle.
  - Pop happens only on acknowledge, as described below.
  - Simultaneous push and pop leaves `count` unchanged.
  - Pointers wrap modulo `DEPTH`.
  - `full` and `empty` are derived from `count` and change in the cycle after the causing edge.
- FSM states: IDLE, PRESENT, RELEASE, GAP.
- IDLE:
  - `in_dev_hs`=0.
  - If `empty`=0 at the clock edge: load the head byte into the `input_bus` register, set `in_dev_hs`=1 and go to PRESENT.
  - Latency: a byte pushed into an empty FIFO at edge N gives `in_dev_hs`=1 after edge N+1.
- PRESENT:
  - `in_dev_hs`=1 and `input_bus` are held stable.
  - When `in_dev_ack`=1 is sampled: pop the FIFO, increment `sent_count`, clear `in_dev_hs`, go to RELEASE.
  - `in_dev_ack` sampled in any other state is ignored and never pops.
- RELEASE:
  - `in_dev_hs`=0 and `input_bus` retains the last byte.
  - Stay here while `in_dev_ack`=1.
  - When `in_dev_ack`=0 is sampled, load the gap counter with `GAP_CYCLES` and go to GAP.
- GAP:
  - `in_dev_hs`=0; the gap counter decrements each cycle.
  - When the counter reaches 0: go to PRESENT (loading the next head byte and raising `in_dev_hs`) if `empty`=0, otherwise go to IDLE.
- Protocol guarantees:
  - `in_dev_hs` is never high in two adjacent transfers without at least one low cycle between them.
  - `input_bus` never changes while `in_dev_hs`=1.
- Ordering: bytes are delivered strictly in FIFO order; no byte is duplicated or skipped.
- Outputs are registered; there is no combinational path from `in_dev_ack` to `in_dev_hs`.

Test Plan:
- Reset, then push 8'h0A; hold ack at 0.
  -> `in_dev_hs`=1 and `input_bus`=8'h0A from the second edge after the push, held indefinitely; `count`=1.
- Push 8'h11, 8'h22, 8'h33; pulse ack for one cycle per byte, releasing after each.
  -> Bus shows 8'h11, 8'h22, 8'h33 in order; `in_dev_hs` low for at least 1+`GAP_CYCLES` cycles between bytes; `sent_count`=3; `empty`=1.
- Push 9 bytes 8'h01..8'h09 with ack held at 0.
  -> `full`=1 after the 8th push; 8'h09 dropped; `count`=8; the later drain delivers only 8'h01..8'h08.
- Hold ack at 1 for 5 cycles after the first byte.
  -> FSM stays in RELEASE; `in_dev_hs`=0 for all 5 cycles; only one pop; `sent_count`=1.
- Assert `g_clr`=0 while in PRESENT with 3 bytes queued.
  -> `in_dev_hs`=0 and `count`=0 immediately, without waiting for a clock edge; after release, nothing is presented until a new push.
- Push 256 bytes and acknowledge all.
  -> `sent_count` wraps to 8'h00.
